reg_file: RTL and testbench

- General-purpose register file for the RISC-Z 16-bit datapath.
- 16 registers x 16 bits.
- Two combinational read ports feed the ALU operands.
- One synchronous write port is driven by writeback.

---
 rtl/reg_file.sv | 57 +++++
 tb/tb_reg_file.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, writes visible after the edge; REG_FILE_BYPASS_EN forwards WriteData before it.
// Backpressure: none, every write and read completes unconditionally.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] RD,
  input  logic              RegW,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] RO1,
  output logic [DATA_W-1:0] RO2
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (RegW) begin
      regs_d[RD] = WriteData;
    end
  end

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_en;

  always_comb begin
    fwd_en = RegW && !rst;
    RO1    = (fwd_en && (RD == R1)) ? WriteData : regs_q[R1];
    RO2    = (fwd_en && (RD == R2)) ? WriteData : regs_q[R2];
  end
`else
  always_comb begin
    RO1 = regs_q[R1];
    RO2 = regs_q[R2];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, fill, write disable, dual read, read-during-write, reset vs write.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [3:0]  R1;
  logic [3:0]  R2;
  logic [3:0]  RD;
  logic        RegW;
  logic [15:0] WriteData;
  logic [15:0] RO1;
  logic [15:0] RO2;

  int checks;
  int errors;

  reg_file #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .R1        (R1),
    .R2        (R2),
    .RD        (RD),
    .RegW      (RegW),
    .WriteData (WriteData),
    .RO1       (RO1),
    .RO2       (RO2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_rdw;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    R1        = 4'd0;
    R2        = 4'd0;
    RD        = 4'd0;
    RegW      = 1'b0;
    WriteData = 16'h0;
    tick();
    rst = 1'b0;

    R1 = 4'd0;
    R2 = 4'd1;
    #1;
    check("reset_ro1_r0", RO1, 16'h0000);
    check("reset_ro2_r1", RO2, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      R1 = a[3:0];
      R2 = 4'(15 - a);
      #1;
      check("reset_sweep_ro1", RO1, 16'h0000);
      check("reset_sweep_ro2", RO2, 16'h0000);
    end

    RegW = 1'b1;
    for (int k = 0; k < 16; k++) begin
      RD        = k[3:0];
      WriteData = 16'(k);
      tick();
    end
    RegW = 1'b0;
    for (int p = 0; p < 16; p += 2) begin
      R1 = p[3:0];
      R2 = 4'(p + 1);
      #1;
      check("fill_ro1", RO1, 16'(p));
      check("fill_ro2", RO2, 16'(p + 1));
    end

    RegW      = 1'b0;
    RD        = 4'd5;
    WriteData = 16'hBEEF;
    tick();
    R1 = 4'd5;
    #1;
    check("wdis_r5", RO1, 16'h0005);

    R1 = 4'd9;
    R2 = 4'd9;
    #1;
    check("dual_ro1_r9", RO1, 16'h0009);
    check("dual_ro2_r9", RO2, 16'h0009);

    RegW      = 1'b1;
    RD        = 4'd15;
    WriteData = 16'hFFFF;
    tick();
    RegW = 1'b0;
    R1   = 4'd15;
    R2   = 4'd14;
    #1;
    check("full_width_r15", RO1, 16'hFFFF);
    check("neighbour_r14", RO2, 16'h000E);

    R1        = 4'd3;
    R2        = 4'd4;
    RD        = 4'd3;
    WriteData = 16'h1234;
    RegW      = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_rdw = 16'h1234;
`else
    exp_rdw = 16'h0003;
`endif
    check("rdw_before_edge", RO1, exp_rdw);
    check("rdw_other_port", RO2, 16'h0004);
    tick();
    RegW = 1'b0;
    #1;
    check("rdw_after_edge", RO1, 16'h1234);

    R1 = 4'd7;
    R2 = 4'd3;
    #1;
    check("pre_reset_r7", RO1, 16'h0007);
    rst       = 1'b1;
    RegW      = 1'b1;
    RD        = 4'd7;
    WriteData = 16'hAAAA;
    #1;
    // Forwarding is suppressed while rst is high, so the stored value shows in both builds.
    check("rst_cycle_r7", RO1, 16'h0007);
    tick();
    rst  = 1'b0;
    RegW = 1'b0;
    #1;
    check("rst_vs_write_r7", RO1, 16'h0000);
    check("rst_clears_r3", RO2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
